// File: rtl/cache_refill_pkg.sv
// Shared constants and state encoding for the cache line refill engine.
package cache_refill_pkg;

   localparam int CACHE_INDEX_AW = 8;
   localparam int RAM_NUM        = 4;
   localparam int BANK_NUM       = 4;
   localparam int DATA_WIDTH     = 32;
   localparam int LINE_OFF_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } refill_state_t;

endpackage

// File: rtl/cache_refill.sv
// Cache line refill engine: fetches one 4-beat line from memory and writes it
// into the data banks, then writes the tag.
//
//   state | meaning
//   IDLE  | waiting for a miss; request latched on miss_req_i
//   REQ   | line read request presented, waiting for mem_req_ready_i
//   RECV  | accepting response beats, one bank per beat
//   DONE  | tag/valid write and completion pulse, one cycle
module cache_refill
   import cache_refill_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = cache_refill_pkg::DATA_WIDTH,
   parameter int INDEX_AW   = cache_refill_pkg::CACHE_INDEX_AW,
   parameter int BANK_NUM   = cache_refill_pkg::BANK_NUM,
   parameter int RAM_NUM    = cache_refill_pkg::RAM_NUM
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    miss_req_i,
   input  logic [ADDR_WIDTH-1:0]                   miss_addr_i,
   output logic                                    refill_busy_o,
   output logic                                    refill_done_o,
   output logic                                    refill_err_o,
   output logic                                    mem_req_valid_o,
   input  logic                                    mem_req_ready_i,
   output logic [ADDR_WIDTH-1:0]                   mem_req_addr_o,
   input  logic                                    mem_rsp_valid_i,
   output logic                                    mem_rsp_ready_o,
   input  logic [DATA_WIDTH-1:0]                   mem_rsp_data_i,
   input  logic                                    mem_rsp_last_i,
   output logic [INDEX_AW-1:0]                     bank_index_o,
   output logic [BANK_NUM*RAM_NUM-1:0]             bank_wr_en_o,
   output logic [DATA_WIDTH-1:0]                   bank_wr_data_o,
   output logic                                    tag_wr_en_o,
   output logic [ADDR_WIDTH-INDEX_AW-LINE_OFF_W-1:0] tag_o
);

   localparam int         WE_W     = BANK_NUM * RAM_NUM;
   localparam int         TAG_W    = ADDR_WIDTH - INDEX_AW - LINE_OFF_W;
   localparam logic [1:0] CNT_LAST = 2'(BANK_NUM - 1);

   refill_state_t         r_state;
   refill_state_t         w_next;
   logic [1:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_line_addr;
   logic [INDEX_AW-1:0]   r_index;
   logic [TAG_W-1:0]      r_tag;
   logic [WE_W-1:0]       r_wr_en;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_err;
   logic                  w_accept;
   logic                  w_cnt_last;
   logic                  w_start;
   logic [WE_W-1:0]       w_beat_en;
   logic                  w_unused_offset;

   // The byte offset is irrelevant to a whole-line refill.
   assign w_unused_offset = ^miss_addr_i[LINE_OFF_W-1:0];

   assign w_start    = (r_state == ST_IDLE) && miss_req_i;
   assign w_accept   = (r_state == ST_RECV) && mem_rsp_valid_i;
   assign w_cnt_last = (r_cnt == CNT_LAST);
   assign w_beat_en  = {{(WE_W-RAM_NUM){1'b0}}, {RAM_NUM{1'b1}}} << (int'(r_cnt) * RAM_NUM);

   assign mem_req_addr_o = r_line_addr;
   assign bank_index_o   = r_index;
   assign tag_o          = r_tag;
   assign bank_wr_en_o   = r_wr_en;
   assign bank_wr_data_o = r_wr_data;
   assign refill_err_o   = r_err;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      w_next          = r_state;
      refill_busy_o   = 1'b1;
      mem_req_valid_o = 1'b0;
      mem_rsp_ready_o = 1'b0;
      refill_done_o   = 1'b0;
      tag_wr_en_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            refill_busy_o = 1'b0;
            if (miss_req_i) w_next = ST_REQ;
         end
         ST_REQ: begin
            mem_req_valid_o = 1'b1;
            if (mem_req_ready_i) w_next = ST_RECV;
         end
         ST_RECV: begin
            mem_rsp_ready_o = 1'b1;
            if (w_accept && w_cnt_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            refill_done_o = 1'b1;
            tag_wr_en_o   = 1'b1;
            w_next        = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Latch line address, index and tag when a miss is taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line_addr <= '0;
         r_index     <= '0;
         r_tag       <= '0;
      end else if (w_start) begin
         r_line_addr <= {miss_addr_i[ADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
         r_index     <= miss_addr_i[INDEX_AW+LINE_OFF_W-1:LINE_OFF_W];
         r_tag       <= miss_addr_i[ADDR_WIDTH-1:INDEX_AW+LINE_OFF_W];
      end
   end

   // Beat counter, registered bank write port and last-marker check.
   // Completion follows the counter; a wrong last marker only raises an error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_wr_en   <= '0;
         r_wr_data <= '0;
         r_err     <= 1'b0;
      end else begin
         r_wr_en <= '0;
         r_err   <= 1'b0;
         if ((r_state == ST_REQ) && mem_req_ready_i) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_cnt     <= r_cnt + 2'd1;
            r_wr_en   <= w_beat_en;
            r_wr_data <= mem_rsp_data_i;
            r_err     <= (mem_rsp_last_i != w_cnt_last);
         end
      end
   end

endmodule

// File: tb/tb_cache_refill.sv
// Self-checking bench for the cache line refill engine.
module tb_cache_refill;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_req_i;
   logic [31:0] miss_addr_i;
   logic        refill_busy_o;
   logic        refill_done_o;
   logic        refill_err_o;
   logic        mem_req_valid_o;
   logic        mem_req_ready_i;
   logic [31:0] mem_req_addr_o;
   logic        mem_rsp_valid_i;
   logic        mem_rsp_ready_o;
   logic [31:0] mem_rsp_data_i;
   logic        mem_rsp_last_i;
   logic [7:0]  bank_index_o;
   logic [15:0] bank_wr_en_o;
   logic [31:0] bank_wr_data_o;
   logic        tag_wr_en_o;
   logic [19:0] tag_o;

   cache_refill #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .INDEX_AW(8), .BANK_NUM(4), .RAM_NUM(4)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_req_i(miss_req_i), .miss_addr_i(miss_addr_i),
      .refill_busy_o(refill_busy_o), .refill_done_o(refill_done_o),
      .refill_err_o(refill_err_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_req_addr_o(mem_req_addr_o),
      .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
      .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_last_i(mem_rsp_last_i),
      .bank_index_o(bank_index_o), .bank_wr_en_o(bank_wr_en_o),
      .bank_wr_data_o(bank_wr_data_o),
      .tag_wr_en_o(tag_wr_en_o), .tag_o(tag_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      addr;
      int               req_wait;   // cycles ready is held low while valid
      logic [3:0]       gap;        // bit k: one idle response cycle after beat k
      logic [3:0]       last;       // last marker driven with beat k
      logic [3:0][31:0] data;
      logic [31:0]      exp_line;
      logic [7:0]       exp_index;
      logic [19:0]      exp_tag;
      int               exp_done;   // cycle of refill_done_o, request edge = cycle 0
      int               exp_err;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic any_out();
      return |{refill_busy_o, refill_done_o, refill_err_o, mem_req_valid_o, mem_req_addr_o,
               mem_rsp_ready_o, bank_index_o, bank_wr_en_o, bank_wr_data_o, tag_wr_en_o, tag_o};
   endfunction

   function automatic vec_t mk(input logic [31:0] a, input int w, input logic [3:0] g,
                               input logic [3:0] l, input logic [31:0] line,
                               input logic [7:0] idx, input logic [19:0] tag,
                               input int done, input int err);
      vec_t v;
      v.addr = a; v.req_wait = w; v.gap = g; v.last = l;
      for (int k = 0; k < 4; k++) v.data[k] = $urandom;
      v.exp_line = line; v.exp_index = idx; v.exp_tag = tag;
      v.exp_done = done; v.exp_err = err;
      return v;
   endfunction

   // Reference model: line/index/tag by address arithmetic, latency as
   // request phase + beats + idle gaps + completion cycle.
   function automatic vec_t model(input logic [31:0] a, input int w, input logic [3:0] g,
                                  input logic [3:0] l);
      vec_t v;
      int gaps = 0;
      int errs = 0;
      for (int k = 0; k < 3; k++) if (g[k]) gaps++;
      for (int k = 0; k < 4; k++) if (l[k] != (k == 3)) errs++;
      v = mk(a, w, g, l, (a / 16) * 16, 8'((a / 16) % 256), 20'(a / 4096),
             (w + 1) + 4 + gaps + 1, errs);
      return v;
   endfunction

   // One refill: issue the miss, play a reactive memory, collect what the
   // banks see, then compare. rst_cyc > 0 aborts with reset at that cycle.
   task automatic run_refill(input vec_t v, input bit miss_in_recv, input int rst_cyc);
      int cyc = 0, beat = 0, hs = 0, errs = 0, done_cyc = 0, tag_seen = 0;
      int wait_left;
      bit gap_pending = 1'b0;
      bit aborted = 1'b0;
      logic [15:0] wq_mask[$];
      logic [31:0] wq_data[$];
      wait_left = v.req_wait;
      miss_req_i  = 1'b1;
      miss_addr_i = v.addr;
      @(posedge clk);
      #1;
      miss_req_i  = 1'b0;
      miss_addr_i = $urandom;
      while (done_cyc == 0 && !aborted && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bank_wr_en_o != 16'h0) begin
            chk("write_after_handshake", hs, 1);
            wq_mask.push_back(bank_wr_en_o);
            wq_data.push_back(bank_wr_data_o);
         end
         if (refill_err_o) errs++;
         if (tag_wr_en_o) tag_seen++;
         if (refill_busy_o) chk("bank_index_held", bank_index_o, v.exp_index);
         if (mem_req_valid_o) chk("req_addr_held", mem_req_addr_o, v.exp_line);
         if (refill_done_o) begin
            done_cyc = cyc;
            chk("tag_wr_with_done", tag_wr_en_o, 1);
            chk("tag_value", tag_o, v.exp_tag);
         end
         if (cyc == rst_cyc) begin
            // zero-wait memory: beats 0 and 1 have been written by cycle 4
            chk("writes_before_rst", wq_mask.size(), 2);
            rst = 1'b1;
            mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
            mem_rsp_last_i = 1'b0; miss_req_i = 1'b0;
            #1;
            chk("outputs_zero_in_rst", any_out(), 0);
            @(negedge clk);
            chk("outputs_zero_after_rst_edge", any_out(), 0);
            if (tag_wr_en_o) tag_seen++;
            rst = 1'b0;
            aborted = 1'b1;
         end else begin
            mem_req_ready_i = 1'b0;
            if (mem_req_valid_o) begin
               if (wait_left > 0) wait_left--;
               else begin
                  mem_req_ready_i = 1'b1;
                  hs++;
               end
            end
            if (mem_rsp_ready_o && !gap_pending && beat < 4) begin
               mem_rsp_valid_i = 1'b1;
               mem_rsp_data_i  = v.data[beat];
               mem_rsp_last_i  = v.last[beat];
               gap_pending     = v.gap[beat];
               beat++;
            end else begin
               mem_rsp_valid_i = 1'b0;
               mem_rsp_data_i  = $urandom;
               mem_rsp_last_i  = 1'($urandom_range(0, 1));
               if (mem_rsp_ready_o) gap_pending = 1'b0;
            end
            miss_req_i  = miss_in_recv && mem_rsp_ready_o;
            miss_addr_i = $urandom;
         end
      end
      if (aborted) begin
         chk("no_tag_write_on_abort", tag_seen, 0);
      end else begin
         chk("done_latency", done_cyc, v.exp_done);
         chk("write_count", wq_mask.size(), 4);
         for (int k = 0; k < 4 && k < wq_mask.size(); k++) begin
            chk("write_nibble", wq_mask[k], 16'hF << (4 * k));
            chk("write_data", wq_data[k], v.data[k]);
         end
         chk("err_pulses", errs, v.exp_err);
         chk("one_handshake", hs, 1);
         chk("tag_wr_once", tag_seen, 1);
         @(negedge clk);
         chk("back_to_idle",
             {refill_busy_o, refill_done_o, tag_wr_en_o, refill_err_o, |bank_wr_en_o}, 0);
      end
   endtask

   vec_t tbl[5];
   vec_t v;

   initial begin
      rst = 1'b1;
      miss_req_i = 1'b0; miss_addr_i = '0;
      mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
      mem_rsp_data_i = '0; mem_rsp_last_i = 1'b0;

      //           addr          wait gap     last     line          idx    tag        done err
      tbl[0] = mk(32'h8000_1234, 0, 4'b0000, 4'b1000, 32'h8000_1230, 8'h23, 20'h80001, 6, 0);
      tbl[1] = mk(32'h0000_0FFC, 3, 4'b0000, 4'b1000, 32'h0000_0FF0, 8'hFF, 20'h00000, 9, 0);
      tbl[2] = mk(32'h1234_5678, 0, 4'b0110, 4'b1000, 32'h1234_5670, 8'h67, 20'h12345, 8, 0);
      tbl[3] = mk(32'hFFFF_FFFF, 0, 4'b0000, 4'b1010, 32'hFFFF_FFF0, 8'hFF, 20'hFFFFF, 6, 1);
      tbl[4] = mk(32'h0000_0010, 1, 4'b0001, 4'b0000, 32'h0000_0010, 8'h01, 20'h00000, 8, 1);

      repeat (2) @(negedge clk);
      chk("reset_outputs", any_out(), 0);
      rst = 1'b0;
      chk("idle_after_reset", any_out(), 0);

      for (int i = 0; i < 5; i++) run_refill(tbl[i], 1'b0, 0);

      // reset after two beats, then a clean refill straight after
      v = mk(32'h4000_ABC4, 0, 4'b0000, 4'b1000, 32'h4000_ABC0, 8'hBC, 20'h4000A, 6, 0);
      run_refill(v, 1'b0, 4);
      v = mk(32'h8000_1234, 0, 4'b0000, 4'b1000, 32'h8000_1230, 8'h23, 20'h80001, 6, 0);
      run_refill(v, 1'b0, 0);

      // miss requests during RECV must be ignored
      v = mk(32'h5555_AAA8, 0, 4'b0010, 4'b1000, 32'h5555_AAA0, 8'hAA, 20'h5555A, 7, 0);
      run_refill(v, 1'b1, 0);

      for (int i = 0; i < 25; i++) begin
         logic [3:0] l;
         l = ($urandom_range(0, 1) == 1) ? 4'b1000 : 4'($urandom_range(0, 15));
         v = model($urandom, $urandom_range(0, 3), 4'($urandom_range(0, 15)), l);
         run_refill(v, 1'($urandom_range(0, 1)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
